// File: rtl/fu_pkg.sv
// Opcode encodings plus latency and result helpers for the pipelined ALU functional unit.
package fu_pkg;

  // fu_compute works on a 64-bit container, so the unit supports XLEN up to 64.
  localparam int unsigned FU_MAX_W = 64;

  typedef enum logic [3:0] {
    OP_NONE   = 4'b0000,
    OP_OR     = 4'b0001,
    OP_ADD    = 4'b0010,
    OP_XOR    = 4'b0011,
    OP_LUI    = 4'b0100,
    OP_SRA    = 4'b1011,
    OP_NONE_F = 4'b1111
  } alu_op_e;

  function automatic logic fu_is_legal(input logic [3:0] op);
    case (op)
      OP_NONE, OP_OR, OP_ADD, OP_XOR, OP_LUI, OP_SRA, OP_NONE_F: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] fu_latency(input logic [3:0] op);
    case (op)
      OP_ADD:  return 3'd2;
      OP_SRA:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // lhs arrives sign-extended to FU_MAX_W so the arithmetic shift pulls in the right sign bit.
  function automatic logic [FU_MAX_W-1:0] fu_compute(input logic [3:0]          op,
                                                     input logic [FU_MAX_W-1:0] lhs,
                                                     input logic [FU_MAX_W-1:0] rhs,
                                                     input logic [5:0]          shamt);
    logic signed [FU_MAX_W-1:0] lhs_s;
    lhs_s = lhs;
    case (op)
      OP_OR:   return lhs | rhs;
      OP_ADD:  return lhs + rhs;
      OP_XOR:  return lhs ^ rhs;
      OP_LUI:  return rhs;
      OP_SRA:  return lhs_s >>> shamt;
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/fu_result_fifo.sv
// DEPTH-entry result FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module fu_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + PTR_W'(1);
      if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/pipelined_alu_fu.sv
// Single-slot ALU functional unit with a result FIFO draining to the wakeup and LSQ buses.
// Optional flush port enabled by defining PIPELINED_ALU_FU_FLUSH_EN.
module pipelined_alu_fu
  import fu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned ROB_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_ctrl,
  input  logic             in_alu_src,
  input  logic             in_is_for_lsq,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_rs1_value,
  input  logic [XLEN-1:0]  in_rs2_value,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [ROB_W-1:0] in_rob,
  output logic             wk_valid,
  input  logic             wk_ready,
  output logic [TAG_W-1:0] wk_tag,
  output logic [ROB_W-1:0] wk_rob,
  output logic [XLEN-1:0]  wk_value,
  output logic             lsq_valid,
  input  logic             lsq_ready,
  output logic [ROB_W-1:0] lsq_rob,
  output logic [XLEN-1:0]  lsq_value,
`ifdef PIPELINED_ALU_FU_FLUSH_EN
  input  logic             flush,
`endif
  output logic             err
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned PAY_W = TAG_W + ROB_W + 1 + XLEN;

  logic                    busy_q, busy_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [3:0]              op_q, op_d;
  logic signed [XLEN-1:0]  lhs_q, lhs_d;
  logic [XLEN-1:0]         rhs_q, rhs_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [ROB_W-1:0]        rob_q, rob_d;
  logic                    lsq_q, lsq_d;

  logic                    flush_w;
  logic [2:0]              lat;
  logic                    finishing, can_push, push, pop, accept;
  logic [XLEN-1:0]         result;
  logic [PAY_W-1:0]        push_data, head_data;
  logic                    fifo_full, fifo_empty;
  logic                    head_lsq;
  logic [TAG_W-1:0]        head_tag;
  logic [ROB_W-1:0]        head_rob;
  logic [XLEN-1:0]         head_value;

`ifdef PIPELINED_ALU_FU_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign lat       = fu_latency(op_q);
  assign finishing = busy_q && (cnt_q == lat - 3'd1);

  assign {head_tag, head_rob, head_lsq, head_value} = head_data;
  assign wk_valid  = !fifo_empty && !head_lsq;
  assign lsq_valid = !fifo_empty && head_lsq;
  assign pop       = (wk_valid && wk_ready) || (lsq_valid && lsq_ready);

  // A finishing op may retire into a full FIFO only when the head leaves in the same cycle.
  assign can_push = !fifo_full || pop;
  assign push     = finishing && can_push && !flush_w;
  assign in_ready = (!busy_q || push) && !flush_w;
  assign accept   = in_valid && in_ready;

  assign result    = XLEN'(fu_compute(op_q, FU_MAX_W'(lhs_q), FU_MAX_W'(rhs_q),
                                      6'(rhs_q[SH_W-1:0])));
  assign push_data = {tag_q, rob_q, lsq_q, result};

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    op_d   = op_q;
    lhs_d  = lhs_q;
    rhs_d  = rhs_q;
    tag_d  = tag_q;
    rob_d  = rob_q;
    lsq_d  = lsq_q;
    if (flush_w) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (accept) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      op_d   = in_alu_ctrl;
      lhs_d  = in_rs1_value;
      // LUI always takes the immediate, whatever the source select says.
      rhs_d  = (in_alu_src || in_alu_ctrl == OP_LUI) ? in_imm : in_rs2_value;
      tag_d  = in_tag;
      rob_d  = in_rob;
      lsq_d  = in_is_for_lsq;
      if (!fu_is_legal(in_alu_ctrl)) err_d = 1'b1;
    end else if (push) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q && !finishing) begin
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    lhs_q <= lhs_d;
    rhs_q <= rhs_d;
    tag_q <= tag_d;
    rob_q <= rob_d;
    lsq_q <= lsq_d;
  end

  fu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (PAY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush_w),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wk_tag    = wk_valid  ? head_tag   : '0;
  assign wk_rob    = wk_valid  ? head_rob   : '0;
  assign wk_value  = wk_valid  ? head_value : '0;
  assign lsq_rob   = lsq_valid ? head_rob   : '0;
  assign lsq_value = lsq_valid ? head_value : '0;
  assign err       = err_q;

endmodule
